// File: rtl/painterengine_gpu_display_scheduler_if.sv
// Host/display-core signal bundle for the GPU display frame scheduler.
// The master side (host register file plus display core pins) drives the
// requests and the status lines. The slave side is the scheduler itself.
interface painterengine_gpu_display_scheduler_if;
   logic        i_wire_enable;
   logic [31:0] i_wire_buffer0_address;
   logic [31:0] i_wire_buffer1_address;
   logic        i_wire_swap_request;
   logic        i_wire_error_clear;
   logic        i_wire_display_done;
   logic        i_wire_display_error;
   logic        o_wire_display_resetn;
   logic [31:0] o_wire_image_address;
   logic        o_wire_front_index;
   logic        o_wire_swap_ack;
   logic [31:0] o_wire_frame_count;
   logic        o_wire_busy;
   logic        o_wire_error;
   logic [1:0]  o_wire_error_code;

   modport master (
      output i_wire_enable, i_wire_buffer0_address, i_wire_buffer1_address,
             i_wire_swap_request, i_wire_error_clear, i_wire_display_done,
             i_wire_display_error,
      input  o_wire_display_resetn, o_wire_image_address, o_wire_front_index,
             o_wire_swap_ack, o_wire_frame_count, o_wire_busy, o_wire_error,
             o_wire_error_code
   );

   modport slave (
      input  i_wire_enable, i_wire_buffer0_address, i_wire_buffer1_address,
             i_wire_swap_request, i_wire_error_clear, i_wire_display_done,
             i_wire_display_error,
      output o_wire_display_resetn, o_wire_image_address, o_wire_front_index,
             o_wire_swap_ack, o_wire_frame_count, o_wire_busy, o_wire_error,
             o_wire_error_code
   );
endinterface

// File: rtl/painterengine_gpu_display_scheduler.sv
// GPU display frame scheduler.
// Restarts the display core once per frame by pulsing its active-low reset,
// presents a stable framebuffer base address per frame, applies host swap
// requests only between frames, and supervises the core with an error latch
// and a per-frame watchdog. All outputs come straight from flops.
module painterengine_gpu_display_scheduler #(
   parameter int unsigned RESTART_GAP     = 16,
   parameter int unsigned WATCHDOG_CYCLES = 50_000_000
) (
   input logic                                   i_wire_clock,
   input logic                                   i_wire_resetn,
   painterengine_gpu_display_scheduler_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_RUN   = 3'd2,
      ST_GAP   = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   localparam logic [15:0] GAP_LAST  = 16'(RESTART_GAP - 32'd1);
   localparam logic        WDOG_EN   = (WATCHDOG_CYCLES != 32'd0);
   localparam logic [31:0] WDOG_LAST = 32'(WATCHDOG_CYCLES - 32'd1);

   state_t      state_q;
   logic        display_resetn_q;
   logic [31:0] image_address_q;
   logic        front_index_q;
   logic        swap_ack_q;
   logic [31:0] frame_count_q;
   logic        busy_q;
   logic        error_q;
   logic [1:0]  error_code_q;
   logic        swap_pending_q;
   logic [15:0] gap_cnt_q;
   logic [31:0] wdog_cnt_q;

   logic        swap_pending_d;
   logic        front_index_d;
   logic        gap_last_s;
   logic        swap_service_s;
   logic        wdog_expired_s;
   logic [31:0] start_address_s;

   // Swap bookkeeping, watchdog expiry and next-frame address selection.
   always_comb begin
      gap_last_s      = (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);
      // Swaps are only applied while the core is held in reset: in IDLE or
      // on the final GAP cycle. A request landing on the service cycle merges.
      swap_service_s  = swap_pending_q && ((state_q == ST_IDLE) || gap_last_s);
      if (swap_service_s) begin
         swap_pending_d = 1'b0;
         front_index_d  = ~front_index_q;
      end else begin
         swap_pending_d = swap_pending_q | bus.i_wire_swap_request;
         front_index_d  = front_index_q;
      end
      wdog_expired_s  = WDOG_EN && (wdog_cnt_q == WDOG_LAST);
      if (front_index_q) begin
         start_address_s = bus.i_wire_buffer1_address;
      end else begin
         start_address_s = bus.i_wire_buffer0_address;
      end
   end

   // Frame sequencing FSM with all status outputs registered alongside it.
   always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
      if (!i_wire_resetn) begin
         state_q          <= ST_IDLE;
         display_resetn_q <= 1'b0;
         image_address_q  <= 32'd0;
         front_index_q    <= 1'b0;
         swap_ack_q       <= 1'b0;
         frame_count_q    <= 32'd0;
         busy_q           <= 1'b0;
         error_q          <= 1'b0;
         error_code_q     <= 2'b00;
         swap_pending_q   <= 1'b0;
         gap_cnt_q        <= 16'd0;
         wdog_cnt_q       <= 32'd0;
      end else begin
         swap_pending_q <= swap_pending_d;
         front_index_q  <= front_index_d;
         swap_ack_q     <= swap_service_s;
         case (state_q)
            ST_IDLE: begin
               display_resetn_q <= 1'b0;
               if (bus.i_wire_enable) begin
                  state_q <= ST_START;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_START: begin
               image_address_q  <= start_address_s;
               display_resetn_q <= 1'b1;
               wdog_cnt_q       <= 32'd0;
               state_q          <= ST_RUN;
            end
            ST_RUN: begin
               if (bus.i_wire_display_error) begin
                  display_resetn_q <= 1'b0;
                  error_code_q     <= 2'b01;
                  error_q          <= 1'b1;
                  busy_q           <= 1'b0;
                  state_q          <= ST_ERROR;
               end else if (bus.i_wire_display_done) begin
                  frame_count_q    <= frame_count_q + 32'd1;
                  display_resetn_q <= 1'b0;
                  gap_cnt_q        <= 16'd0;
                  state_q          <= ST_GAP;
               end else if (wdog_expired_s) begin
                  display_resetn_q <= 1'b0;
                  error_code_q     <= 2'b10;
                  error_q          <= 1'b1;
                  busy_q           <= 1'b0;
                  state_q          <= ST_ERROR;
               end else begin
                  wdog_cnt_q <= wdog_cnt_q + 32'd1;
               end
            end
            ST_GAP: begin
               display_resetn_q <= 1'b0;
               if (gap_last_s) begin
                  if (bus.i_wire_enable) begin
                     state_q <= ST_START;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q + 16'd1;
               end
            end
            ST_ERROR: begin
               display_resetn_q <= 1'b0;
               if (bus.i_wire_error_clear) begin
                  error_q      <= 1'b0;
                  error_code_q <= 2'b00;
                  state_q      <= ST_IDLE;
               end else begin
                  state_q <= ST_ERROR;
               end
            end
            default: begin
               display_resetn_q <= 1'b0;
               busy_q           <= 1'b0;
               error_q          <= 1'b0;
               error_code_q     <= 2'b00;
               state_q          <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.o_wire_display_resetn = display_resetn_q;
   assign bus.o_wire_image_address  = image_address_q;
   assign bus.o_wire_front_index    = front_index_q;
   assign bus.o_wire_swap_ack       = swap_ack_q;
   assign bus.o_wire_frame_count    = frame_count_q;
   assign bus.o_wire_busy           = busy_q;
   assign bus.o_wire_error          = error_q;
   assign bus.o_wire_error_code     = error_code_q;

endmodule

// File: tb/tb_painterengine_gpu_display_scheduler.sv
// Self-checking bench for the GPU display frame scheduler: directed frame,
// swap, error, watchdog and reset scenarios followed by randomized frames
// checked against a frame-level model (expected front buffer, frame count,
// swap acknowledges and inter-frame reset length).
module tb_painterengine_gpu_display_scheduler;
   localparam int GAP = 4;
   localparam int WD  = 50;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   passes = 0;
   int   fails  = 0;

   painterengine_gpu_display_scheduler_if bus ();

   painterengine_gpu_display_scheduler #(
      .RESTART_GAP     (GAP),
      .WATCHDOG_CYCLES (WD)
   ) u_dut (
      .i_wire_clock  (clk),
      .i_wire_resetn (rst_n),
      .bus           (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observer: swap_ack count, reset-low run lengths, and stability of the
   // address/front index while the display core is out of reset.
   int          ack_total = 0;
   int          rises     = 0;
   int          low_run   = 0;
   int          last_low  = 0;
   int          stab_viol = 0;
   logic        prev_rn   = 1'b0;
   logic [31:0] prev_addr = 32'd0;
   logic        prev_front = 1'b0;
   always @(negedge clk) begin
      if (bus.o_wire_swap_ack === 1'b1) ack_total <= ack_total + 1;
      if (bus.o_wire_display_resetn !== 1'b1) begin
         low_run <= low_run + 1;
      end else begin
         if (prev_rn !== 1'b1) begin
            last_low <= low_run;
            rises    <= rises + 1;
         end
         low_run <= 0;
         if (prev_rn === 1'b1 && (bus.o_wire_image_address !== prev_addr ||
                                  bus.o_wire_front_index !== prev_front))
            stab_viol <= stab_viol + 1;
      end
      prev_rn    <= bus.o_wire_display_resetn;
      prev_addr  <= bus.o_wire_image_address;
      prev_front <= bus.o_wire_front_index;
   end

   // Frame-level reference state.
   logic [31:0] buf0, buf1;
   logic [31:0] exp_fc;
   logic        exp_front;

   function automatic logic [31:0] exp_addr();
      return exp_front ? buf1 : buf0;
   endfunction

   task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_b(input string tag, input logic obs, input logic exp);
      check_w(tag, {31'd0, obs}, {31'd0, exp});
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_rn(input logic val, input int budget, input string tag);
      int n;
      n = 0;
      while (bus.o_wire_display_resetn !== val && n < budget) begin
         tick();
         n++;
      end
      check_b(tag, bus.o_wire_display_resetn, val);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_b({tag, "_resetn"}, bus.o_wire_display_resetn, 1'b0);
      check_w({tag, "_addr"},   bus.o_wire_image_address, 32'd0);
      check_b({tag, "_front"},  bus.o_wire_front_index, 1'b0);
      check_b({tag, "_ack"},    bus.o_wire_swap_ack, 1'b0);
      check_w({tag, "_fc"},     bus.o_wire_frame_count, 32'd0);
      check_b({tag, "_busy"},   bus.o_wire_busy, 1'b0);
      check_b({tag, "_error"},  bus.o_wire_error, 1'b0);
      check_w({tag, "_code"},   {30'd0, bus.o_wire_error_code}, 32'd0);
   endtask

   // One frame from its first RUN cycle to the first RUN cycle of the next
   // frame (enable held high). Swap pulses land only while the core runs.
   task automatic frame(input int d, input int swap_pct, input bit inject_err);
      int  ack0;
      int  nsw;
      logic swapped;
      ack0 = ack_total;
      nsw  = 0;
      check_w("frame_addr",  bus.o_wire_image_address, exp_addr());
      check_b("frame_front", bus.o_wire_front_index, exp_front);
      check_b("frame_busy",  bus.o_wire_busy, 1'b1);
      for (int c = 0; c < d; c++) begin
         bus.i_wire_swap_request = ($urandom_range(99) < swap_pct) ? 1'b1 : 1'b0;
         if (bus.i_wire_swap_request) nsw++;
         tick();
      end
      bus.i_wire_swap_request = 1'b0;
      swapped = (nsw > 0);
      if (inject_err) begin
         bus.i_wire_display_error = 1'b1;
         bus.i_wire_display_done  = ($urandom_range(1) == 1) ? 1'b1 : 1'b0;
         tick();
         bus.i_wire_display_error = 1'b0;
         bus.i_wire_display_done  = 1'b0;
         check_b("rerr_error", bus.o_wire_error, 1'b1);
         check_w("rerr_code",  {30'd0, bus.o_wire_error_code}, 32'd1);
         check_w("rerr_fc",    bus.o_wire_frame_count, exp_fc);
         check_b("rerr_rn",    bus.o_wire_display_resetn, 1'b0);
         repeat ($urandom_range(1, 6)) tick();
         bus.i_wire_error_clear = 1'b1;
         tick();
         bus.i_wire_error_clear = 1'b0;
         check_b("rerr_cleared", bus.o_wire_error, 1'b0);
         wait_rn(1'b1, 20, "rerr_restart_timeout");
      end else begin
         bus.i_wire_display_done = 1'b1;
         tick();
         bus.i_wire_display_done = 1'b0;
         exp_fc = exp_fc + 32'd1;
         check_w("frame_count", bus.o_wire_frame_count, exp_fc);
         check_b("frame_end_rn", bus.o_wire_display_resetn, 1'b0);
         wait_rn(1'b1, 20, "frame_restart_timeout");
         check_w("gap_low_len", 32'(last_low), 32'(GAP + 1));
      end
      if (swapped) exp_front = ~exp_front;
      check_w("swap_ack_count", 32'(ack_total - ack0), swapped ? 32'd1 : 32'd0);
   endtask

   initial begin
      int ack0;
      int rises0;
      rst_n = 1'b0;
      bus.i_wire_enable          = 1'b0;
      bus.i_wire_swap_request    = 1'b0;
      bus.i_wire_error_clear     = 1'b0;
      bus.i_wire_display_done    = 1'b0;
      bus.i_wire_display_error   = 1'b0;
      buf0 = 32'h1000_0000;
      buf1 = 32'h2000_0000;
      bus.i_wire_buffer0_address = buf0;
      bus.i_wire_buffer1_address = buf1;
      exp_fc    = 32'd0;
      exp_front = 1'b0;

      repeat (3) tick();
      check_reset_outputs("rst");
      rst_n = 1'b1;
      repeat (2) tick();
      check_reset_outputs("idle");

      // Enable rising: START one cycle later, core out of reset the next.
      bus.i_wire_enable = 1'b1;
      tick();
      check_b("start_rn_low", bus.o_wire_display_resetn, 1'b0);
      check_b("start_busy",   bus.o_wire_busy, 1'b1);
      tick();
      check_b("start_rn_high", bus.o_wire_display_resetn, 1'b1);
      check_w("start_fc0",     bus.o_wire_frame_count, 32'd0);
      for (int i = 0; i < 3; i++) frame(20, 0, 1'b0);

      // Directed swap mid-frame, applied on the last GAP cycle.
      repeat (5) tick();
      bus.i_wire_swap_request = 1'b1;
      tick();
      bus.i_wire_swap_request = 1'b0;
      repeat (5) tick();
      check_w("swap_addr_hold",  bus.o_wire_image_address, 32'h1000_0000);
      check_b("swap_front_hold", bus.o_wire_front_index, 1'b0);
      bus.i_wire_display_done = 1'b1;
      tick();
      bus.i_wire_display_done = 1'b0;
      exp_fc = exp_fc + 32'd1;
      check_w("swap_fc", bus.o_wire_frame_count, exp_fc);
      for (int k = 0; k < GAP - 1; k++) begin
         tick();
         check_b("swap_ack_early", bus.o_wire_swap_ack, 1'b0);
      end
      tick();
      check_b("swap_ack_last_gap", bus.o_wire_swap_ack, 1'b1);
      check_b("swap_front_new",    bus.o_wire_front_index, 1'b1);
      check_b("swap_rn_still_low", bus.o_wire_display_resetn, 1'b0);
      tick();
      check_b("swap_ack_single", bus.o_wire_swap_ack, 1'b0);
      check_b("swap_rn_high",    bus.o_wire_display_resetn, 1'b1);
      check_w("swap_addr_new",   bus.o_wire_image_address, 32'h2000_0000);
      exp_front = 1'b1;

      // Three pulses in one frame merge into a single swap.
      ack0 = ack_total;
      for (int k = 0; k < 3; k++) begin
         bus.i_wire_swap_request = 1'b1;
         tick();
         bus.i_wire_swap_request = 1'b0;
         repeat (2) tick();
      end
      bus.i_wire_display_done = 1'b1;
      tick();
      bus.i_wire_display_done = 1'b0;
      exp_fc = exp_fc + 32'd1;
      wait_rn(1'b1, 20, "merge_restart_timeout");
      exp_front = 1'b0;
      check_w("merge_ack_count", 32'(ack_total - ack0), 32'd1);
      check_w("merge_addr", bus.o_wire_image_address, exp_addr());

      // Dropping enable mid-frame lets the frame finish, then idles.
      repeat (3) tick();
      bus.i_wire_enable = 1'b0;
      repeat (5) tick();
      check_b("drop_no_abort", bus.o_wire_display_resetn, 1'b1);
      rises0 = rises;
      bus.i_wire_display_done = 1'b1;
      tick();
      bus.i_wire_display_done = 1'b0;
      exp_fc = exp_fc + 32'd1;
      check_w("drop_fc", bus.o_wire_frame_count, exp_fc);
      repeat (GAP + 8) tick();
      check_b("drop_idle_rn",   bus.o_wire_display_resetn, 1'b0);
      check_b("drop_idle_busy", bus.o_wire_busy, 1'b0);
      check_w("drop_no_restart", 32'(rises - rises0), 32'd0);

      // Swap request in IDLE is acknowledged one cycle later.
      bus.i_wire_swap_request = 1'b1;
      tick();
      bus.i_wire_swap_request = 1'b0;
      check_b("idle_swap_pending", bus.o_wire_swap_ack, 1'b0);
      tick();
      check_b("idle_swap_ack",   bus.o_wire_swap_ack, 1'b1);
      check_b("idle_swap_front", bus.o_wire_front_index, 1'b1);
      tick();
      check_b("idle_swap_ack_off", bus.o_wire_swap_ack, 1'b0);
      exp_front = 1'b1;

      // Error and done together: error wins, frame not counted.
      bus.i_wire_enable = 1'b1;
      wait_rn(1'b1, 10, "err_start_timeout");
      check_w("err_addr", bus.o_wire_image_address, exp_addr());
      repeat (4) tick();
      bus.i_wire_display_error = 1'b1;
      bus.i_wire_display_done  = 1'b1;
      tick();
      bus.i_wire_display_error = 1'b0;
      bus.i_wire_display_done  = 1'b0;
      check_b("err_flag", bus.o_wire_error, 1'b1);
      check_w("err_code", {30'd0, bus.o_wire_error_code}, 32'd1);
      check_w("err_fc",   bus.o_wire_frame_count, exp_fc);
      check_b("err_rn",   bus.o_wire_display_resetn, 1'b0);
      check_b("err_busy", bus.o_wire_busy, 1'b0);
      repeat (3) tick();
      check_b("err_latched", bus.o_wire_error, 1'b1);
      bus.i_wire_enable      = 1'b0;
      bus.i_wire_error_clear = 1'b1;
      tick();
      bus.i_wire_error_clear = 1'b0;
      check_b("err_clear_flag", bus.o_wire_error, 1'b0);
      check_w("err_clear_code", {30'd0, bus.o_wire_error_code}, 32'd0);
      repeat (3) tick();
      check_b("err_idle_rn", bus.o_wire_display_resetn, 1'b0);

      // Watchdog fires exactly WD RUN cycles after the core leaves reset.
      bus.i_wire_enable = 1'b1;
      wait_rn(1'b1, 10, "wd_start_timeout");
      bus.i_wire_enable = 1'b0;
      repeat (WD - 1) tick();
      check_b("wd_not_yet",    bus.o_wire_error, 1'b0);
      check_b("wd_rn_running", bus.o_wire_display_resetn, 1'b1);
      tick();
      check_b("wd_error", bus.o_wire_error, 1'b1);
      check_w("wd_code",  {30'd0, bus.o_wire_error_code}, 32'd2);
      check_b("wd_rn",    bus.o_wire_display_resetn, 1'b0);
      check_w("wd_fc",    bus.o_wire_frame_count, exp_fc);
      bus.i_wire_error_clear = 1'b1;
      tick();
      bus.i_wire_error_clear = 1'b0;
      check_w("wd_clear_code", {30'd0, bus.o_wire_error_code}, 32'd0);

      // Randomized frames against the frame-level model.
      buf0 = $urandom;
      buf1 = $urandom;
      bus.i_wire_buffer0_address = buf0;
      bus.i_wire_buffer1_address = buf1;
      bus.i_wire_enable = 1'b1;
      wait_rn(1'b1, 10, "rand_start_timeout");
      for (int f = 0; f < 16; f++)
         frame(int'($urandom_range(0, 40)), 15, ($urandom_range(3) == 0));
      check_w("addr_stable_while_running", 32'(stab_viol), 32'd0);

      // Asynchronous reset mid-RUN clears outputs without waiting for a clock.
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
